gs_ddram_bridge: RTL and testbench

// - Byte-wide bridge from the General Sound (GS) memory port to the DDR3 Avalon-style port (DDRAM_*).
// - Maps the 2 MB GS address space onto 64-bit DDR words.
// - Stalls the GS core through ready; reads are served from a one-line 64-bit cache when CONFIGURATION enables it.
// - Sits between tsconf GS_* signals and the DDRAM_* top-level pins.

---
 rtl/gs_ddram_pkg.sv | 32 +++
 rtl/gs_ddram_line_cache.sv | 38 +++
 rtl/gs_ddram_bridge.sv | 160 ++++++++++++++++
 tb/tb_gs_ddram_bridge.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gs_ddram_pkg.sv
// Shared types and helpers for the GS-to-DDR3 bridge.
// The GS_DDRAM_CACHE_EN build option enables the one-line read cache.
package gs_ddram_pkg;

  localparam int unsigned GS_AW  = 21;
  localparam int unsigned DDR_AW = 29;
  localparam int unsigned DDR_DW = 64;
  localparam int unsigned TAG_W  = 18;

  localparam logic [DDR_AW-1:0] DEFAULT_BASE_ADDR = 29'h0600_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_CMD  = 2'd1,
    RD_CMD  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  // Command payload presented on the DDR port.
  typedef struct packed {
    logic [DDR_AW-1:0] addr;
    logic [DDR_DW-1:0] data;
    logic [7:0]        be;
  } ddr_cmd_t;

  // Byte lane i of a 64-bit word; lane 0 is the least significant byte.
  function automatic logic [7:0] lane_sel(input logic [DDR_DW-1:0] word,
                                          input logic [2:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/gs_ddram_line_cache.sv
// Single-line 64-bit read cache: tag, valid, data, with fill and byte-write ports.
module gs_ddram_line_cache
  import gs_ddram_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [TAG_W-1:0]  lookup_tag,
  output logic              hit_c,
  output logic [DDR_DW-1:0] line,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DDR_DW-1:0] fill_data,
  input  logic              wr,
  input  logic [2:0]        wr_lane,
  input  logic [7:0]        wr_data
);

  logic             valid;
  logic [TAG_W-1:0] tag;

  assign hit_c = valid && (tag == lookup_tag);

  // Writes only touch the line when they land on it, keeping it coherent with DDR.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      tag   <= '0;
      line  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      line  <= fill_data;
    end else if (wr && hit_c) begin
      line[{wr_lane, 3'b000} +: 8] <= wr_data;
    end
  end

endmodule

// File: rtl/gs_ddram_bridge.sv
// Byte-wide GS memory port to 64-bit DDR3 Avalon-style port bridge.
// Define GS_DDRAM_CACHE_EN to serve reads from a one-line cache.
module gs_ddram_bridge
  import gs_ddram_pkg::*;
#(
  parameter logic [28:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  state_t            state, state_nxt;
  logic              old_rd, old_we;
  logic [GS_AW-1:0]  last_addr;
  logic [GS_AW-1:0]  req_addr;
  ddr_cmd_t          cmd, cmd_nxt;

  logic              rd_nxt, we_nxt;
  logic [7:0]        dout_nxt;
  logic              accept;
  logic              fill;
  logic              cache_wr;
  logic              addr_chg_c, wr_req_c, rd_req_c;
  logic              hit_c;
  logic [DDR_DW-1:0] line;

  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = cmd.addr;
  assign DDRAM_DIN      = cmd.data;
  assign DDRAM_BE       = cmd.be;

  // A request is an edge on its strobe or an address change while the strobe is held.
  assign addr_chg_c = (addr != last_addr);
  assign wr_req_c   = we && (!old_we || addr_chg_c);
  assign rd_req_c   = rd && (!old_rd || addr_chg_c);

`ifdef GS_DDRAM_CACHE_EN
  gs_ddram_line_cache u_cache (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .lookup_tag (addr[20:3]),
    .hit_c      (hit_c),
    .line       (line),
    .fill       (fill),
    .fill_tag   (req_addr[20:3]),
    .fill_data  (DDRAM_DOUT),
    .wr         (cache_wr),
    .wr_lane    (addr[2:0]),
    .wr_data    (din)
  );
`else
  logic unused_cache;
  assign hit_c        = 1'b0;
  assign line         = '0;
  assign unused_cache = &{1'b0, fill, cache_wr, req_addr[20:3]};
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_nxt    = DDRAM_RD;
    we_nxt    = DDRAM_WE;
    dout_nxt  = dout;
    accept    = 1'b0;
    fill      = 1'b0;
    cache_wr  = 1'b0;
    ready     = 1'b0;
    cmd_nxt.addr = BASE_ADDR + DDR_AW'(addr[20:3]);
    cmd_nxt.data = {8{din}};
    cmd_nxt.be   = 8'(8'b1 << addr[2:0]);

    unique case (state)
      IDLE: begin
        ready = !(wr_req_c || rd_req_c);
        // Write wins when both strobes request in the same cycle.
        if (wr_req_c) begin
          accept    = 1'b1;
          cache_wr  = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = WR_CMD;
        end else if (rd_req_c) begin
          accept = 1'b1;
          if (hit_c) begin
            dout_nxt = lane_sel(line, addr[2:0]);
          end else begin
            rd_nxt    = 1'b1;
            state_nxt = RD_CMD;
          end
        end
      end
      WR_CMD: begin
        if (!DDRAM_BUSY) begin
          we_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      RD_CMD: begin
        if (!DDRAM_BUSY) begin
          rd_nxt    = 1'b0;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (DDRAM_DOUT_READY) begin
          dout_nxt  = lane_sel(DDRAM_DOUT, req_addr[2:0]);
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobe history is only tracked in IDLE so edges during a transaction are seen afterwards.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      DDRAM_RD  <= 1'b0;
      DDRAM_WE  <= 1'b0;
      dout      <= '0;
      old_rd    <= 1'b0;
      old_we    <= 1'b0;
      last_addr <= '0;
      req_addr  <= '0;
      cmd       <= '0;
    end else begin
      DDRAM_RD <= rd_nxt;
      DDRAM_WE <= we_nxt;
      dout     <= dout_nxt;
      if (state == IDLE) begin
        old_rd <= rd;
        old_we <= we;
      end
      if (accept) begin
        last_addr <= addr;
        req_addr  <= addr;
        cmd       <= cmd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// Directed bench for gs_ddram_bridge; expectations follow the GS_DDRAM_CACHE_EN build option.
module tb_gs_ddram_bridge;

  localparam logic [28:0] BASE = 29'h0600_0000;
`ifdef GS_DDRAM_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [20:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        rd, we, ready;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT;
  logic        DDRAM_DOUT_READY;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  int n_tests = 0;
  int n_fail  = 0;

  gs_ddram_bridge dut (
    .clk_sys          (clk_sys),
    .reset_n          (reset_n),
    .addr             (addr),
    .din              (din),
    .dout             (dout),
    .rd               (rd),
    .we               (we),
    .ready            (ready),
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE)
  );

  always #5 clk_sys = ~clk_sys;

  // mode: 0 read, 1 write, 2 read+write together
  typedef struct {
    int          mode;
    logic [20:0] a;
    logic [7:0]  d;
    int          busy;
    logic [63:0] word;
    logic [28:0] e_addr;
    logic [7:0]  e_be;
    logic [7:0]  e_dout;
    int          e_we;
    int          e_rd;
    int          e_low;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int mode, input logic [20:0] a, input logic [7:0] d,
                              input int busy, input logic [63:0] word, input logic [28:0] e_addr,
                              input logic [7:0] e_be, input logic [7:0] e_dout,
                              input int e_we, input int e_rd, input int e_low);
    vec_t v;
    v.mode = mode; v.a = a; v.d = d; v.busy = busy; v.word = word;
    v.e_addr = e_addr; v.e_be = e_be; v.e_dout = e_dout;
    v.e_we = e_we; v.e_rd = e_rd; v.e_low = e_low;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents one request and plays the DDR side until the bridge is idle, plus two settle cycles.
  task automatic txn(input vec_t v, output int we_c, output int rd_c, output int low,
                     output logic [28:0] c_addr, output logic [7:0] c_be,
                     output logic [63:0] c_din, output logic [7:0] c_dout, output bit to);
    int  busy_left;
    bit  pend;
    bit  done;
    int  extra;
    we_c = 0; rd_c = 0; low = 0; c_addr = '0; c_be = '0; c_din = '0; c_dout = '0;
    busy_left = v.busy; pend = 1'b0; done = 1'b0; extra = 0;
    @(negedge clk_sys);
    addr = v.a; din = v.d;
    we = (v.mode != 0);
    rd = (v.mode != 1);
    #1;
    if (!ready) low++;
    for (int k = 0; k < 40 && extra < 2; k++) begin
      @(negedge clk_sys);
      if (DDRAM_WE) begin we_c++; c_addr = DDRAM_ADDR; c_be = DDRAM_BE; c_din = DDRAM_DIN; end
      if (DDRAM_RD) begin rd_c++; c_addr = DDRAM_ADDR; end
      if (!ready) low++;
      if (done) extra++;
      else if (ready && !DDRAM_RD && !DDRAM_WE) begin done = 1'b1; c_dout = dout; end
      DDRAM_DOUT_READY = pend;
      if (pend) DDRAM_DOUT = v.word;
      pend = 1'b0;
      DDRAM_BUSY = 1'b0;
      if (DDRAM_RD || DDRAM_WE) begin
        if (busy_left > 0) begin DDRAM_BUSY = 1'b1; busy_left--; end
        else if (DDRAM_RD) pend = 1'b1;
      end
    end
    to = !done;
    rd = 1'b0; we = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int we_c, rd_c, low;
    logic [28:0] c_addr;
    logic [7:0]  c_be, c_dout;
    logic [63:0] c_din;
    bit to;
    txn(v, we_c, rd_c, low, c_addr, c_be, c_din, c_dout, to);
    check({tag, " timeout"}, 64'(to), 64'd0);
    check({tag, " we_cycles"}, 64'(we_c), 64'(v.e_we));
    check({tag, " rd_cycles"}, 64'(rd_c), 64'(v.e_rd));
    check({tag, " ready_low"}, 64'(low), 64'(v.e_low));
    if (v.e_we > 0) begin
      check({tag, " wr_addr"}, 64'(c_addr), 64'(v.e_addr));
      check({tag, " be"}, 64'(c_be), 64'(v.e_be));
      check({tag, " din"}, c_din, {8{v.d}});
    end
    if (v.mode == 0) check({tag, " dout"}, 64'(c_dout), 64'(v.e_dout));
    if (v.e_rd > 0) check({tag, " rd_addr"}, 64'(c_addr), 64'(v.e_addr));
  endtask

  initial begin
    reset_n = 1'b0; addr = '0; din = '0; rd = 1'b0; we = 1'b0;
    DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;

    vecs[0]  = mk(1, 21'h00005, 8'hA5, 0, 64'h0, BASE,            8'h20, 8'h00, 1, 0, 2);
    vecs[1]  = mk(0, 21'h00008, 8'h00, 0, 64'h1122334455667788, BASE + 29'd1, 8'h00, 8'h88, 0, 1, 3);
    vecs[2]  = mk(0, 21'h0000F, 8'h00, 0, 64'h1122334455667788, BASE + 29'd1, 8'h00, 8'h11,
                  0, CACHE ? 0 : 1, CACHE ? 1 : 3);
    vecs[3]  = mk(1, 21'h0000A, 8'h5A, 0, 64'h0, BASE + 29'd1,    8'h04, 8'h00, 1, 0, 2);
    vecs[4]  = mk(0, 21'h0000A, 8'h00, 0, 64'h1122334455_5A_7788, BASE + 29'd1, 8'h00, 8'h5A,
                  0, CACHE ? 0 : 1, CACHE ? 1 : 3);
    vecs[5]  = mk(0, 21'h00010, 8'h00, 5, 64'h0102030405060708, BASE + 29'd2, 8'h00, 8'h08, 0, 6, 8);
    vecs[6]  = mk(1, 21'h1FFFFF, 8'h3C, 0, 64'h0, 29'h0603FFFF,   8'h80, 8'h00, 1, 0, 2);
    vecs[7]  = mk(1, 21'h00003, 8'h77, 3, 64'h0, BASE,            8'h08, 8'h00, 4, 0, 5);
    vecs[8]  = mk(0, 21'h1FFFF8, 8'h00, 0, 64'hCAFEBABEDEADBEEF, 29'h0603FFFF, 8'h00, 8'hEF, 0, 1, 3);
    vecs[9]  = mk(0, 21'h1FFFFD, 8'h00, 0, 64'hCAFEBABEDEADBEEF, 29'h0603FFFF, 8'h00, 8'hBA,
                  0, CACHE ? 0 : 1, CACHE ? 1 : 3);
    vecs[10] = mk(2, 21'h00020, 8'h99, 0, 64'h0, BASE + 29'd4,    8'h01, 8'h00, 1, 0, 2);

    repeat (3) @(negedge clk_sys);
    check("rst DDRAM_RD", 64'(DDRAM_RD), 64'd0);
    check("rst DDRAM_WE", 64'(DDRAM_WE), 64'd0);
    check("rst dout", 64'(dout), 64'd0);
    check("rst ready", 64'(ready), 64'd1);
    check("rst burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) run_and_check($sformatf("v%0d", i), vecs[i]);

    // Reset pulsed while a read is waiting for data must drop it and invalidate the cache.
    run_and_check("pre_rst", mk(0, 21'h00040, 8'h00, 0, 64'h42, BASE + 29'd8, 8'h00, 8'h42, 0, 1, 3));
    @(negedge clk_sys);
    addr = 21'h00080; rd = 1'b1;
    @(negedge clk_sys);
    check("mid RD issued", 64'(DDRAM_RD), 64'd1);
    DDRAM_BUSY = 1'b0;
    @(negedge clk_sys);
    check("mid RD dropped", 64'(DDRAM_RD), 64'd0);
    check("mid waiting", 64'(ready), 64'd0);
    reset_n = 1'b0; rd = 1'b0;
    #1;
    check("arst DDRAM_RD", 64'(DDRAM_RD), 64'd0);
    check("arst DDRAM_WE", 64'(DDRAM_WE), 64'd0);
    check("arst ready", 64'(ready), 64'd1);
    check("arst dout", 64'(dout), 64'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    run_and_check("post_rst", mk(0, 21'h00040, 8'h00, 0, 64'h77, BASE + 29'd8, 8'h00, 8'h77, 0, 1, 3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
